// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the segment-masked single-port SRAM.
package sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A word must split into equal, non-empty mask segments.
    function automatic bit gran_ok(input int data_w, input int segs);
        return (segs > 0) && (data_w >= segs) && ((data_w % segs) == 0);
    endfunction

    function automatic bit geom_ok(input int depth, input int addr_w);
        return (depth >= 2) && (depth <= 4096) && (addr_w >= clog2(depth));
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Init sweep sequencer: writes every word once after reset or on request, then
// reports the array ready for user traffic.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sram_state_e       state_reg;
    sram_state_e       state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign init_we   = (state_reg == ST_INIT);
    assign init_addr = cnt_reg;
    assign ready     = (state_reg == ST_READY);

endmodule

// File: rtl/sram_sp_masked_init.sv
// Single-port segment-masked SRAM with self-initialisation and 1- or 2-cycle
// read latency; read data holds between reads and is never X.
module sram_sp_masked_init
    import sram_pkg::*;
#(
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 516,
    parameter int                MASK_SEGS  = 2,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                 RW0_clk,
    input  logic                 RW0_reset,
    input  logic [ADDR_W-1:0]    RW0_addr,
    input  logic                 RW0_en,
    input  logic                 RW0_wmode,
    input  logic [MASK_SEGS-1:0] RW0_wmask,
    input  logic [DATA_W-1:0]    RW0_wdata,
    output logic [DATA_W-1:0]    RW0_rdata,
    output logic                 RW0_rvalid,
    output logic                 RW0_ready,
    input  logic                 init_req
);

    localparam int                GRAN      = DATA_W / MASK_SEGS;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    if (!gran_ok(DATA_W, MASK_SEGS)) begin : g_bad_gran
        $error("sram_sp_masked_init: DATA_W must be a multiple of MASK_SEGS");
    end
    if (!geom_ok(DEPTH, ADDR_W)) begin : g_bad_geom
        $error("sram_sp_masked_init: DEPTH must be 2..4096 and fit in ADDR_W");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $error("sram_sp_masked_init: RD_LAT must be 1 or 2");
    end

    logic                 init_we;
    logic [ADDR_W-1:0]    init_addr;
    logic                 ready;

    sram_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (RW0_clk),
        .rst       (RW0_reset),
        .init_req  (init_req),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    assign RW0_ready = ready;

    logic                 addr_in_range;
    logic                 user_wr;
    logic                 rd_fire;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [MASK_SEGS-1:0] mem_wmask;

    assign addr_in_range = ({1'b0, RW0_addr} < DEPTH_LIM);
    assign user_wr       = RW0_en & RW0_wmode & ready & addr_in_range;
    assign rd_fire       = RW0_en & ~RW0_wmode & ready;
    // Out-of-range reads fetch word 0 so the array is never indexed past its end.
    assign rd_addr       = addr_in_range ? RW0_addr : '0;

    // The sweep and user writes never overlap: ready and init_we are exclusive.
    assign mem_we    = init_we | user_wr;
    assign mem_waddr = init_we ? init_addr : RW0_addr;
    assign mem_wdata = init_we ? INIT_VALUE : RW0_wdata;

    for (genvar gi = 0; gi < MASK_SEGS; gi++) begin : g_wmask
        assign mem_wmask[gi] = init_we | RW0_wmask[gi];
    end

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] mem_q;

    always_ff @(posedge RW0_clk) begin
        if (mem_we) begin
            for (int s = 0; s < MASK_SEGS; s++) begin
                if (mem_wmask[s]) begin
                    mem[mem_waddr][s*GRAN +: GRAN] <= mem_wdata[s*GRAN +: GRAN];
                end
            end
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (rd_fire) begin
            mem_q <= mem[rd_addr];
        end
    end

    // hit_reg qualifies the un-reset array output: cleared by reset and by
    // out-of-range reads, so the visible data is zero in both cases.
    logic              s1_valid_reg;
    logic              s1_hit_reg;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= rd_fire;
            if (rd_fire) begin
                s1_hit_reg <= addr_in_range;
            end
        end
    end

    assign s1_data = s1_hit_reg ? mem_q : '0;

    if (RD_LAT == 1) begin : g_lat1
        assign RW0_rdata  = s1_data;
        assign RW0_rvalid = s1_valid_reg;
    end else begin : g_lat2
        logic [DATA_W-1:0] rdata_reg;
        logic              rvalid_reg;

        always_ff @(posedge RW0_clk or posedge RW0_reset) begin
            if (RW0_reset) begin
                rdata_reg  <= '0;
                rvalid_reg <= 1'b0;
            end else begin
                rvalid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    rdata_reg <= s1_data;
                end
            end
        end

        assign RW0_rdata  = rdata_reg;
        assign RW0_rvalid = rvalid_reg;
    end

endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Bench for sram_sp_masked_init: two instances (DEPTH 32 / RD_LAT 1 and
// DEPTH 20 / RD_LAT 2) share one stimulus stream and are checked every cycle.
module tb_sram_sp_masked_init;

    localparam int DW   = 516;
    localparam int AW   = 5;
    localparam int SEGS = 2;
    localparam int G    = DW / SEGS;
    localparam logic [DW-1:0] INIT_A = '0;
    localparam logic [DW-1:0] INIT_B = {129{4'hC}};
    localparam logic [DW-1:0] PAT_A5 = {4'h5, {64{8'hA5}}};

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            en       = 1'b0;
    logic            wmode    = 1'b0;
    logic            init_req = 1'b0;
    logic [AW-1:0]   addr     = '0;
    logic [SEGS-1:0] wmask    = '0;
    logic [DW-1:0]   wdata    = '0;

    logic [DW-1:0] rdata_w [2];
    logic          rvalid_w [2];
    logic          ready_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_sp_masked_init #(
        .DEPTH(32), .ADDR_W(AW), .DATA_W(DW), .MASK_SEGS(SEGS), .RD_LAT(1), .INIT_VALUE(INIT_A)
    ) dut_a (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_w[0]), .RW0_rvalid(rvalid_w[0]),
        .RW0_ready(ready_w[0]), .init_req(init_req)
    );

    sram_sp_masked_init #(
        .DEPTH(20), .ADDR_W(AW), .DATA_W(DW), .MASK_SEGS(SEGS), .RD_LAT(2), .INIT_VALUE(INIT_B)
    ) dut_b (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_w[1]), .RW0_rvalid(rvalid_w[1]),
        .RW0_ready(ready_w[1]), .init_req(init_req)
    );

    task automatic chk_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    // Model: words become INIT the moment a sweep starts (no access can observe
    // the sweep), the port is ready DEPTH edges after the sweep starts, and each
    // accepted read is due RD_LAT-1 edges after the edge that accepted it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chk
        localparam int D = (gi == 0) ? 32 : 20;
        localparam int L = (gi == 0) ? 1 : 2;
        localparam logic [DW-1:0] IV = (gi == 0) ? INIT_A : INIT_B;

        logic [DW-1:0] mem_m [32];
        logic [DW-1:0] q_data [$];
        int            q_due [$];
        int            since = 0;
        int            edges = 0;
        logic [DW-1:0] last_rd = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                since = 0;
                q_data.delete();
                q_due.delete();
                for (int k = 0; k < 32; k++) mem_m[k] = IV;
            end else begin
                edges++;
                if (since >= D) begin
                    if (en && wmode && (int'(addr) < D)) begin
                        for (int s = 0; s < SEGS; s++)
                            if (wmask[s]) mem_m[addr][s*G +: G] = wdata[s*G +: G];
                    end
                    if (en && !wmode) begin
                        q_due.push_back(edges + L - 1);
                        q_data.push_back((int'(addr) < D) ? mem_m[addr] : '0);
                    end
                    if (init_req) begin
                        since = 0;
                        for (int k = 0; k < 32; k++) mem_m[k] = IV;
                    end
                end else begin
                    since++;
                end
            end
        end

        always @(negedge clk) begin
            logic exp_rv;
            exp_rv = 1'b0;
            if (rst) last_rd = '0;
            if ((q_due.size() > 0) && (q_due[0] == edges)) begin
                exp_rv  = 1'b1;
                last_rd = q_data.pop_front();
                void'(q_due.pop_front());
            end
            chk_bit($sformatf("dut%0d ready", gi), ready_w[gi], since >= D);
            chk_bit($sformatf("dut%0d rvalid", gi), rvalid_w[gi], exp_rv);
            chk_data($sformatf("dut%0d rdata", gi), rdata_w[gi], last_rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int a);
        en = 1'b1; wmode = 1'b0; addr = AW'(a);
        cyc();
        en = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [SEGS-1:0] m);
        en = 1'b1; wmode = 1'b1; addr = AW'(a); wdata = d; wmask = m;
        cyc();
        en = 1'b0; wmode = 1'b0;
    endtask

    task automatic wait_rv(input int i, input logic [DW-1:0] want, input int lat, input string nm);
        int k;
        k = 1;
        while (!rvalid_w[i] && (k < 5)) begin
            cyc();
            k++;
        end
        chk_int({nm, " latency"}, k, lat);
        chk_data({nm, " rdata"}, rdata_w[i], want);
    endtask

    // Counts cycles until each instance reports ready; optionally hammers
    // word 0 with writes during the first drive_n cycles.
    task automatic wait_ready(input string nm, input int start, input int drive_n);
        int fr [2];
        fr[0] = -1;
        fr[1] = -1;
        for (int k = start; k < 40; k++) begin
            for (int i = 0; i < 2; i++)
                if (ready_w[i] && (fr[i] < 0)) fr[i] = k;
            en = (k < drive_n); wmode = 1'b1; addr = '0; wdata = '1; wmask = '1;
            cyc();
        end
        en = 1'b0; wmode = 1'b0;
        chk_int({nm, " ready delay A"}, fr[0], 32);
        chk_int({nm, " ready delay B"}, fr[1], 20);
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) do_read(a);
        repeat (3) cyc();
    endtask

    initial begin
        logic [3:0] nib;

        repeat (3) cyc();
        rst = 1'b0;

        // T1: sweep length and initial contents
        wait_ready("T1", 0, 0);
        read_all();

        // T2: upper segment only
        do_write(5, '1, 2'b10);
        do_read(5);
        wait_rv(0, {{G{1'b1}}, INIT_A[G-1:0]}, 1, "T2 A");
        wait_rv(1, {{G{1'b1}}, INIT_B[G-1:0]}, 2, "T2 B");

        // T3: back-to-back reads of distinct words
        for (int a = 1; a <= 3; a++) begin
            nib = 4'(a);
            do_write(a, {129{nib}}, 2'b11);
        end
        do_read(1);
        do_read(2);
        chk_bit("T3 B rv1", rvalid_w[1], 1'b1);
        chk_data("T3 B d1", rdata_w[1], {129{4'h1}});
        chk_data("T3 A d2", rdata_w[0], {129{4'h2}});
        do_read(3);
        chk_data("T3 B d2", rdata_w[1], {129{4'h2}});
        cyc();
        chk_bit("T3 B rv3", rvalid_w[1], 1'b1);
        chk_data("T3 B d3", rdata_w[1], {129{4'h3}});
        cyc();
        chk_bit("T3 B idle rv", rvalid_w[1], 1'b0);
        chk_data("T3 B hold", rdata_w[1], {129{4'h3}});

        // T4: read-after-write and out-of-range
        do_write(7, PAT_A5, 2'b11);
        do_read(7);
        wait_rv(0, PAT_A5, 1, "T4 raw A");
        wait_rv(1, PAT_A5, 2, "T4 raw B");
        do_read(25);
        wait_rv(0, INIT_A, 1, "T4 oor A");
        wait_rv(1, '0, 2, "T4 oor B");
        do_write(25, '1, 2'b11);
        do_read(25);
        wait_rv(0, '1, 1, "T4 wr25 A");
        wait_rv(1, '0, 2, "T4 wr25 B");
        read_all();

        // T5: init request with a read in the same cycle
        en = 1'b1; wmode = 1'b0; addr = 7; init_req = 1'b1;
        cyc();
        en = 1'b0; init_req = 1'b0;
        chk_bit("T5 A rv", rvalid_w[0], 1'b1);
        chk_data("T5 A d", rdata_w[0], PAT_A5);
        chk_bit("T5 A ready drop", ready_w[0], 1'b0);
        chk_bit("T5 B ready drop", ready_w[1], 1'b0);
        cyc();
        chk_bit("T5 B rv", rvalid_w[1], 1'b1);
        chk_data("T5 B d", rdata_w[1], PAT_A5);
        wait_ready("T5", 1, 15);
        do_read(0);
        wait_rv(0, INIT_A, 1, "T5 word0 A");
        wait_rv(1, INIT_B, 2, "T5 word0 B");
        read_all();

        // T6: reset during a read, then again mid-sweep
        do_read(1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_bit($sformatf("T6 rd rst rv%0d", i), rvalid_w[i], 1'b0);
            chk_bit($sformatf("T6 rd rst ready%0d", i), ready_w[i], 1'b0);
            chk_data($sformatf("T6 rd rst data%0d", i), rdata_w[i], '0);
        end
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        #2 rst = 1'b1;
        #1;
        chk_bit("T6 mid rst ready A", ready_w[0], 1'b0);
        chk_data("T6 mid rst data B", rdata_w[1], '0);
        cyc();
        rst = 1'b0;
        wait_ready("T6", 0, 0);
        do_read(3);
        wait_rv(0, INIT_A, 1, "T6 refill A");
        wait_rv(1, INIT_B, 2, "T6 refill B");
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
